// File: rtl/reg_scan_pkg.sv
// Shared types and helpers for the register-scan self-check block.
package reg_scan_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Counter increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] max_val);
        return (cnt >= max_val) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/reg_scan_cmp.sv
// Registered compare stage: aligns captured regfile data with the 1-cycle
// expected-memory read, counts mismatches and latches the first failure.
module reg_scan_cmp
    import reg_scan_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int ERR_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              issue_vld,
    input  logic [ADDR_W-1:0] issue_idx,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic [DATA_W-1:0] exp_data,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_reg,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] act_q, act_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              seen_q, seen_d;
    logic [ADDR_W-1:0] freg_q, freg_d;
    logic [DATA_W-1:0] fexp_q, fexp_d;
    logic [DATA_W-1:0] fact_q, fact_d;
    logic              mismatch;

    always_comb begin
        vld_d    = issue_vld;
        act_d    = reg_rdata;
        idx_d    = issue_idx;
        err_d    = err_q;
        seen_d   = seen_q;
        freg_d   = freg_q;
        fexp_d   = fexp_q;
        fact_d   = fact_q;
        mismatch = vld_q && (exp_data != act_q);

        if (clear) begin
            err_d  = '0;
            seen_d = 1'b0;
            freg_d = '0;
            fexp_d = '0;
            fact_d = '0;
        end else if (mismatch) begin
            err_d = ERR_W'(sat_inc(32'(err_q), 32'(ERR_MAX)));
            if (!seen_q) begin
                seen_d = 1'b1;
                freg_d = idx_q;
                fexp_d = exp_data;
                fact_d = act_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= 1'b0;
            err_q  <= '0;
            seen_q <= 1'b0;
            freg_q <= '0;
            fexp_q <= '0;
            fact_q <= '0;
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            seen_q <= seen_d;
            freg_q <= freg_d;
            fexp_q <= fexp_d;
            fact_q <= fact_d;
        end
    end

    // Pipeline data is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clock) begin
        act_q <= act_d;
        idx_q <= idx_d;
    end

    assign err_count     = err_q;
    assign first_err_reg = freg_q;
    assign first_err_exp = fexp_q;
    assign first_err_act = fact_q;

endmodule

// File: rtl/reg_scan_checker.sv
// Bring-up self-check: runs the CPU for num_cycles, then scans regfile port A
// against an expected memory. Optional per-register mask: REG_SCAN_MASK_EN.
module reg_scan_checker
    import reg_scan_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CYC_W    = 16,
    parameter int ERR_W    = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
`ifdef REG_SCAN_MASK_EN
    input  logic [NUM_REGS-1:0] check_mask,
`endif
    input  logic [CYC_W-1:0]    num_cycles,
    input  logic [ADDR_W-1:0]   cpu_rs1,
    output logic [ADDR_W-1:0]   rs1_out,
    input  logic [DATA_W-1:0]   reg_rdata,
    output logic [ADDR_W-1:0]   exp_addr,
    input  logic [DATA_W-1:0]   exp_data,
    output logic                test_mode,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_reg,
    output logic [DATA_W-1:0]   first_err_exp,
    output logic [DATA_W-1:0]   first_err_act
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [ADDR_W-1:0] scan_idx_q, scan_idx_d;
    logic              clear_res;
    logic              issue_ok;
    logic              issue_vld;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        scan_idx_d = scan_idx_q;
        clear_res  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear_res  = 1'b1;
                    cyc_d      = num_cycles;
                    scan_idx_d = '0;
                    state_d    = (num_cycles == '0) ? ST_SCAN : ST_RUN;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q - CYC_W'(1);
                if (cyc_q <= CYC_W'(1)) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = '0;
                end
            end
            ST_SCAN: begin
                if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    scan_idx_d = scan_idx_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            scan_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            scan_idx_q <= scan_idx_d;
        end
    end

`ifdef REG_SCAN_MASK_EN
    // Mask is frozen at start so the CPU cannot alter it mid-scan.
    logic [NUM_REGS-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (clear_res) begin
            mask_d = check_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign issue_ok = mask_q[scan_idx_q];
`else
    assign issue_ok = 1'b1;
`endif

    assign issue_vld = (state_q == ST_SCAN) && issue_ok;

    reg_scan_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ERR_W  (ERR_W)
    ) u_cmp (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear_res),
        .issue_vld     (issue_vld),
        .issue_idx     (scan_idx_q),
        .reg_rdata     (reg_rdata),
        .exp_data      (exp_data),
        .err_count     (err_count),
        .first_err_reg (first_err_reg),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act)
    );

    assign test_mode = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign busy      = (state_q == ST_RUN) || test_mode;
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_count == '0);
    assign rs1_out   = test_mode ? scan_idx_q : cpu_rs1;
    assign exp_addr  = scan_idx_q;

endmodule

// File: tb/tb_reg_scan_checker.sv
// Self-checking bench for reg_scan_checker: vector table plus scoreboard queue.
module tb_reg_scan_checker;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int CYC_W    = 16;
    localparam int ERR_W    = 3;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic [CYC_W-1:0]    num_cycles;
    logic [ADDR_W-1:0]   cpu_rs1;
    logic [ADDR_W-1:0]   rs1_out;
    logic [DATA_W-1:0]   reg_rdata;
    logic [ADDR_W-1:0]   exp_addr;
    logic [DATA_W-1:0]   exp_data;
    logic                test_mode, busy, done, pass;
    logic [ERR_W-1:0]    err_count;
    logic [ADDR_W-1:0]   first_err_reg;
    logic [DATA_W-1:0]   first_err_exp, first_err_act;
`ifdef REG_SCAN_MASK_EN
    logic [NUM_REGS-1:0] check_mask;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mem  [NUM_REGS];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CYC_W-1:0]  ncyc;
        int                pat;
        logic [ERR_W-1:0]  err;
        logic              ps;
        logic [ADDR_W-1:0] freg;
        logic [DATA_W-1:0] fexp;
        logic [DATA_W-1:0] fact;
        bit                poke;
    } vec_t;

    vec_t vecs [6];
    vec_t sb_q [$];

    always #5 clock = ~clock;

    assign reg_rdata = regs[rs1_out];
    always @(posedge clock) exp_data <= mem[exp_addr];

    reg_scan_checker #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .CYC_W    (CYC_W),
        .ERR_W    (ERR_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
`ifdef REG_SCAN_MASK_EN
        .check_mask    (check_mask),
`endif
        .num_cycles    (num_cycles),
        .cpu_rs1       (cpu_rs1),
        .rs1_out       (rs1_out),
        .reg_rdata     (reg_rdata),
        .exp_addr      (exp_addr),
        .exp_data      (exp_data),
        .test_mode     (test_mode),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_reg (first_err_reg),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = 32'hA500_0000 + i * 32'h0001_0203;
            mem[i]  = regs[i];
        end
        case (pat)
            1: begin
                regs[3] = 32'd7;  mem[3]  = 32'd9;
                regs[17] = 32'd0; mem[17] = 32'd1;
            end
            2: for (int i = 0; i < NUM_REGS; i++) mem[i] = regs[i] ^ 32'h0000_FFFF;
            3: begin regs[0] = 32'd0; mem[0] = 32'hDEAD_BEEF; end
            4: begin regs[31] = 32'd2; mem[31] = 32'd1; end
            5: begin regs[3] = 32'd7; mem[3] = 32'd9; end
            default: ;
        endcase
    endtask

    task automatic run_vec(input vec_t v);
        int   k, run_cnt, tm_cnt, busy_cnt, scan_k, done_k;
        vec_t e;
        load_pattern(v.pat);
        @(negedge clock);
        num_cycles = v.ncyc;
        start      = 1'b1;
        sb_q.push_back(v);
        @(negedge clock);
        num_cycles = 16'd50;
        k = 1; run_cnt = 0; tm_cnt = 0; busy_cnt = 0; scan_k = -1; done_k = -1;
        while (k <= 400) begin
            if (done) begin
                done_k = k;
                break;
            end
            if (busy && !test_mode) run_cnt++;
            if (busy) busy_cnt++;
            if (test_mode) begin
                tm_cnt++;
                if (scan_k < 0) scan_k = k;
            end
            start = v.poke && (k == 2 || k == int'(v.ncyc) + 5);
            @(negedge clock);
            k++;
        end
        start = 1'b0;
        chk("done_timeout", done_k > 0, 1);
        e = sb_q.pop_front();
        chk("err_count", err_count, e.err);
        chk("pass", pass, e.ps);
        chk("first_err_reg", first_err_reg, e.freg);
        chk("first_err_exp", first_err_exp, e.fexp);
        chk("first_err_act", first_err_act, e.fact);
        chk("run_cycles", run_cnt, e.ncyc);
        chk("test_mode_cycles", tm_cnt, NUM_REGS + 1);
        chk("busy_cycles", busy_cnt, int'(e.ncyc) + NUM_REGS + 1);
        chk("scan_entry", scan_k, int'(e.ncyc) + 1);
        chk("scan_to_done", done_k - scan_k, NUM_REGS + 1);
        repeat (3) @(negedge clock);
        chk("hold_done", done, 1'b1);
        chk("hold_err", err_count, e.err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd3,  1, 3'd2, 1'b0, 5'd3,  32'd9,          32'd7,          1'b0};
        vecs[1] = '{16'd5,  0, 3'd0, 1'b1, 5'd0,  32'd0,          32'd0,          1'b0};
        vecs[2] = '{16'd0,  2, 3'd7, 1'b0, 5'd0,  32'hA500_FFFF,  32'hA500_0000,  1'b0};
        vecs[3] = '{16'd1,  3, 3'd1, 1'b0, 5'd0,  32'hDEAD_BEEF,  32'd0,          1'b0};
        vecs[4] = '{16'd2,  4, 3'd1, 1'b0, 5'd31, 32'd1,          32'd2,          1'b0};
        vecs[5] = '{16'd10, 1, 3'd2, 1'b0, 5'd3,  32'd9,          32'd7,          1'b1};

        reset = 1'b1; start = 1'b0; num_cycles = '0; cpu_rs1 = '0;
`ifdef REG_SCAN_MASK_EN
        check_mask = '1;
`endif
        load_pattern(0);
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_test_mode", test_mode, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err", err_count, 0);
        reset = 1'b0;
        cpu_rs1 = 5'd13; #1;
        chk("idle_rs1_a", rs1_out, 5'd13);
        cpu_rs1 = 5'd22; #1;
        chk("idle_rs1_b", rs1_out, 5'd22);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a scan, then a clean run.
        load_pattern(2);
        @(negedge clock);
        num_cycles = '0; start = 1'b1; cpu_rs1 = 5'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("scan_rs1_idx10", rs1_out, 5'd10);
        chk("scan_exp_addr10", exp_addr, 5'd10);
        chk("scan_err_sat", err_count, 3'd7);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_test_mode", test_mode, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_err", err_count, 0);
        chk("abort_done", done, 1'b0);
        chk("abort_rs1", rs1_out, 5'd5);
        run_vec('{16'd2, 0, 3'd0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0});

        // Start and reset together from DONE: reset wins.
        @(negedge clock);
        reset = 1'b1; start = 1'b1; num_cycles = 16'd4;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        chk("collide_busy", busy, 1'b0);
        chk("collide_done", done, 1'b0);

`ifdef REG_SCAN_MASK_EN
        check_mask = ~(32'd1 << 3);
        run_vec('{16'd4, 5, 3'd0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b1});
        check_mask = ~(32'd1 << 3);
        run_vec('{16'd2, 1, 3'd1, 1'b0, 5'd17, 32'd1, 32'd0, 1'b0});
        check_mask = '1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
